// File: rtl/ifetch_queue_if.sv
// Fetch-queue bundle: cache request/response, branch redirect and decode
// handshake. The master side is the fetch queue itself; the slave side is
// the surrounding pipeline (cache, execute and decode).
interface ifetch_queue_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 128
);

  // Cache side
  logic [DATA_WIDTH-1:0] pc_out;
  logic                  rd_en;
  logic                  abort;
  logic [LINE_WIDTH-1:0] line_in;
  logic                  line_valid;

  // Redirect from execute
  logic                  br_taken;
  logic [DATA_WIDTH-1:0] br_target;

  // Decode side
  logic                  dq_ready;
  logic [DATA_WIDTH-1:0] instr_out;
  logic [DATA_WIDTH-1:0] instr_pc;
  logic                  instr_valid;

  // Occupancy status
  logic                  q_full;
  logic                  q_empty;

  modport master (
    output pc_out, rd_en, abort,
    input  line_in, line_valid,
    input  br_taken, br_target,
    input  dq_ready,
    output instr_out, instr_pc, instr_valid,
    output q_full, q_empty
  );

  modport slave (
    input  pc_out, rd_en, abort,
    output line_in, line_valid,
    output br_taken, br_target,
    output dq_ready,
    input  instr_out, instr_pc, instr_valid,
    input  q_full, q_empty
  );

endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: drives line-aligned fetch addresses into the
// instruction cache, buffers returned 128-bit lines in a small FIFO and
// issues one 32-bit instruction per cycle to decode. A taken branch flushes
// the queue, aborts the cache access and restarts fetch at the target line,
// with issue beginning at the target word inside that line.
module ifetch_queue #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           LINE_WIDTH = 128,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000
) (
  input  logic            clk,
  input  logic            i_rst,
  ifetch_queue_if.master  bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [DATA_WIDTH-1:0] LINE_BYTES = DATA_WIDTH'(32'd16);
  localparam logic [CNT_W-1:0]      CNT_MAX    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1'b1);
  localparam logic [PTR_W-1:0]      PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]      PTR_ONE    = PTR_W'(1'b1);
  localparam logic [DATA_WIDTH-1:0] WORD_ZERO  = {DATA_WIDTH{1'b0}};

  // Pick one instruction word out of a cache line; word 0 is the low lane.
  function automatic logic [DATA_WIDTH-1:0] word_of(
    input logic [LINE_WIDTH-1:0] line,
    input logic [1:0]            idx
  );
    logic [DATA_WIDTH-1:0] w;
    case (idx)
      2'd0:    w = line[1*DATA_WIDTH-1:0*DATA_WIDTH];
      2'd1:    w = line[2*DATA_WIDTH-1:1*DATA_WIDTH];
      2'd2:    w = line[3*DATA_WIDTH-1:2*DATA_WIDTH];
      2'd3:    w = line[4*DATA_WIDTH-1:3*DATA_WIDTH];
      default: w = WORD_ZERO;
    endcase
    return w;
  endfunction

  // Round a byte address down to the start of its 16-byte line.
  function automatic logic [DATA_WIDTH-1:0] line_align(
    input logic [DATA_WIDTH-1:0] addr
  );
    return {addr[DATA_WIDTH-1:4], 4'b0000};
  endfunction

  // Architectural state
  logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]      count_q,    count_d;
  logic [1:0]            rd_word_q,  rd_word_d;

  // Line storage; contents are don't-care until written
  logic [LINE_WIDTH-1:0] line_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] lpc_mem_q  [DEPTH];

  // Control and datapath
  logic                  q_empty_s;
  logic                  q_full_s;
  logic                  rd_en_s;
  logic                  abort_s;
  logic                  instr_valid_s;
  logic                  enq_s;
  logic                  deq_s;
  logic                  pop_s;
  logic [LINE_WIDTH-1:0] head_line_s;
  logic [DATA_WIDTH-1:0] head_pc_s;
  logic [DATA_WIDTH-1:0] instr_out_s;
  logic [DATA_WIDTH-1:0] instr_pc_s;

  // Byte-offset bits of the redirect target carry no meaning for fetch.
  logic unused_tgt_s;
  assign unused_tgt_s = ^bus.br_target[1:0];

  // Handshake qualifiers; reset forces every request and valid low.
  always_comb begin
    q_empty_s     = (count_q == CNT_ZERO);
    q_full_s      = (count_q == CNT_MAX);
    rd_en_s       = 1'b0;
    abort_s       = 1'b0;
    instr_valid_s = 1'b0;
    if (i_rst) begin
      rd_en_s       = 1'b0;
      abort_s       = 1'b0;
      instr_valid_s = 1'b0;
    end else begin
      rd_en_s       = !bus.br_taken && (count_q < CNT_MAX);
      abort_s       = bus.br_taken;
      instr_valid_s = !q_empty_s && !bus.br_taken;
    end
    enq_s = rd_en_s && bus.line_valid;
    deq_s = instr_valid_s && bus.dq_ready;
    pop_s = deq_s && (rd_word_q == 2'd3);
  end

  // Head-of-queue instruction and its PC; zeroed while the queue is empty.
  always_comb begin
    head_line_s = line_mem_q[rd_ptr_q];
    head_pc_s   = lpc_mem_q[rd_ptr_q];
    if (q_empty_s) begin
      instr_out_s = WORD_ZERO;
      instr_pc_s  = WORD_ZERO;
    end else begin
      instr_out_s = word_of(head_line_s, rd_word_q);
      instr_pc_s  = head_pc_s + DATA_WIDTH'({rd_word_q, 2'b00});
    end
  end

  // Next-state logic: a redirect flushes everything, otherwise apply
  // enqueue and dequeue independently.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_word_d  = rd_word_q;
    if (bus.br_taken) begin
      fetch_pc_d = line_align(bus.br_target);
      wr_ptr_d   = PTR_ZERO;
      rd_ptr_d   = PTR_ZERO;
      count_d    = CNT_ZERO;
      rd_word_d  = bus.br_target[3:2];
    end else begin
      if (enq_s) begin
        fetch_pc_d = fetch_pc_q + LINE_BYTES;
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
      end else begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
      end
      if (deq_s) begin
        rd_word_d = rd_word_q + 2'd1;
      end else begin
        rd_word_d = rd_word_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      rd_word_q  <= 2'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_word_q  <= rd_word_d;
    end
  end

  // Line storage write: capture the returned line with its fetch address.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      line_mem_q[wr_ptr_q] <= bus.line_in;
      lpc_mem_q[wr_ptr_q]  <= fetch_pc_q;
    end
  end

  assign bus.pc_out      = fetch_pc_q;
  assign bus.rd_en       = rd_en_s;
  assign bus.abort       = abort_s;
  assign bus.instr_out   = instr_out_s;
  assign bus.instr_pc    = instr_pc_s;
  assign bus.instr_valid = instr_valid_s;
  assign bus.q_full      = q_full_s;
  assign bus.q_empty     = q_empty_s;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  localparam logic [127:0] L0 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] LA = 128'hA0000003_A0000002_A0000001_A0000000;
  localparam logic [127:0] LB = 128'hB0000003_B0000002_B0000001_B0000000;

  logic clk = 1'b0;
  logic i_rst = 1'b1;

  always #5 clk = ~clk;

  ifetch_queue_if #(.DATA_WIDTH(32), .LINE_WIDTH(128)) bus ();

  ifetch_queue #(
    .DATA_WIDTH(32),
    .LINE_WIDTH(128),
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .i_rst(i_rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
  endfunction

  function automatic void chkb(string nm, logic act, logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b required %b (t=%0t)", nm, act, exp, $time);
  endfunction

  // ---------------------------------------------------------------------
  // Reference model: a queue of {line, pc} entries, the fetch address and
  // the index of the next word to issue from the head line.
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic [127:0] line;
    logic [31:0]  pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [1:0]  m_word;
  bit          m_live = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        logic [31:0] e_i;
        logic [31:0] e_p;
        logic        e_full;
        logic        e_empty;
        e_empty = (mq.size() == 0);
        e_full  = (mq.size() == DEPTH);
        if (e_empty) begin
          e_i = 32'd0;
          e_p = 32'd0;
        end else begin
          e_i = 32'(mq[0].line >> (32 * m_word));
          e_p = mq[0].pc + 32'(m_word) * 32'd4;
        end
        chk ("m_pc_out",      bus.pc_out,      m_pc);
        chkb("m_rd_en",       bus.rd_en,       !i_rst && !bus.br_taken && !e_full);
        chkb("m_abort",       bus.abort,       bus.br_taken && !i_rst);
        chkb("m_instr_valid", bus.instr_valid, !e_empty && !bus.br_taken && !i_rst);
        chk ("m_instr_out",   bus.instr_out,   e_i);
        chk ("m_instr_pc",    bus.instr_pc,    e_p);
        chkb("m_q_full",      bus.q_full,      e_full);
        chkb("m_q_empty",     bus.q_empty,     e_empty);
      end
      // Advance the model to the state after the coming rising edge.
      if (i_rst) begin
        mq.delete();
        m_pc   = RESET_PC;
        m_word = 2'd0;
        m_live = 1'b1;
      end else if (m_live) begin
        if (bus.br_taken) begin
          mq.delete();
          m_pc   = {bus.br_target[31:4], 4'h0};
          m_word = bus.br_target[3:2];
        end else begin
          bit enq;
          enq = (mq.size() < DEPTH) && bus.line_valid;
          if ((mq.size() != 0) && bus.dq_ready) begin
            if (m_word == 2'd3) begin
              mq.delete(0);
              m_word = 2'd0;
            end else begin
              m_word = m_word + 2'd1;
            end
          end
          if (enq) begin
            mq.push_back('{line: bus.line_in, pc: m_pc});
            m_pc = m_pc + 32'd16;
          end
        end
      end
    end
  end

  // One cycle: inputs change 1 ns after the rising edge, checks follow the
  // falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #5;
  endtask

  initial begin
    bus.line_in    = L0;
    bus.line_valid = 1'b1;
    bus.br_taken   = 1'b0;
    bus.br_target  = 32'd0;
    bus.dq_ready   = 1'b1;
    i_rst          = 1'b1;

    // --- Reset, release, first line issues 1..4 ---
    step(); step();
    step(); i_rst = 1'b0; settle();
    chk ("rst_pc_out",   bus.pc_out, 32'h0040_0000);
    chkb("rst_rd_en",    bus.rd_en, 1'b1);
    chkb("rst_q_empty",  bus.q_empty, 1'b1);
    chkb("rst_valid",    bus.instr_valid, 1'b0);
    step(); bus.line_valid = 1'b0; settle();
    chk ("w0_instr",     bus.instr_out, 32'h1);
    chk ("w0_pc",        bus.instr_pc, 32'h0040_0000);
    chk ("w0_pc_out",    bus.pc_out, 32'h0040_0010);
    chkb("w0_valid",     bus.instr_valid, 1'b1);
    step(); settle();
    chk ("w1_instr",     bus.instr_out, 32'h2);
    chk ("w1_pc",        bus.instr_pc, 32'h0040_0004);
    step(); settle();
    chk ("w2_instr",     bus.instr_out, 32'h3);
    chk ("w2_pc",        bus.instr_pc, 32'h0040_0008);
    step(); settle();
    chk ("w3_instr",     bus.instr_out, 32'h4);
    chk ("w3_pc",        bus.instr_pc, 32'h0040_000C);

    // --- Fill to DEPTH with decode stalled ---
    step(); i_rst = 1'b1; bus.line_valid = 1'b1; bus.line_in = L0; bus.dq_ready = 1'b0;
    step(); i_rst = 1'b0;
    step(); step(); step();
    step(); settle();
    chkb("full_q_full",  bus.q_full, 1'b1);
    chkb("full_rd_en",   bus.rd_en, 1'b0);
    chk ("full_pc_out",  bus.pc_out, 32'h0040_0040);
    chk ("full_instr",   bus.instr_out, 32'h1);

    // --- Drain one line, refill one ---
    step(); bus.dq_ready = 1'b1;
    step(); step();
    step(); settle();
    chk ("drain_w3",     bus.instr_out, 32'h4);
    step(); bus.dq_ready = 1'b0; settle();
    chkb("refill_rd_en", bus.rd_en, 1'b1);
    chkb("refill_nfull", bus.q_full, 1'b0);
    chk ("refill_pc",    bus.pc_out, 32'h0040_0040);
    step(); settle();
    chkb("refill_full",  bus.q_full, 1'b1);
    chk ("refill_pc2",   bus.pc_out, 32'h0040_0050);
    chk ("refill_ipc",   bus.instr_pc, 32'h0040_0010);

    // --- Redirect with 3 lines queued, line_valid high in the same cycle ---
    step(); bus.dq_ready = 1'b1; bus.line_valid = 1'b0;
    step(); step(); step();
    step(); bus.br_taken = 1'b1; bus.br_target = 32'h0040_0128; bus.line_valid = 1'b1; settle();
    chkb("br_abort",     bus.abort, 1'b1);
    chkb("br_rd_en",     bus.rd_en, 1'b0);
    chkb("br_valid",     bus.instr_valid, 1'b0);
    step(); bus.br_taken = 1'b0; bus.line_in = LA; settle();
    chkb("br_q_empty",   bus.q_empty, 1'b1);
    chk ("br_pc_out",    bus.pc_out, 32'h0040_0120);
    step(); bus.line_in = LB; settle();
    chk ("tgt_pc0",      bus.instr_pc, 32'h0040_0128);
    chk ("tgt_instr0",   bus.instr_out, 32'hA000_0002);
    step(); bus.line_valid = 1'b0; settle();
    chk ("tgt_pc1",      bus.instr_pc, 32'h0040_012C);
    step(); settle();
    chk ("tgt_pc2",      bus.instr_pc, 32'h0040_0130);
    chk ("tgt_instr2",   bus.instr_out, 32'hB000_0000);

    // --- Reset pulse mid-stream ---
    step(); i_rst = 1'b1; bus.line_valid = 1'b1; settle();
    chkb("mrst_valid",   bus.instr_valid, 1'b0);
    chkb("mrst_rd_en",   bus.rd_en, 1'b0);
    step(); i_rst = 1'b0; bus.line_in = L0; settle();
    chkb("mrst_empty",   bus.q_empty, 1'b1);
    chk ("mrst_pc_out",  bus.pc_out, 32'h0040_0000);
    step(); bus.line_valid = 1'b0; settle();
    chk ("mrst_ipc",     bus.instr_pc, 32'h0040_0000);
    chk ("mrst_instr",   bus.instr_out, 32'h1);

    // --- Randomized traffic, checked by the model every cycle ---
    repeat (3000) begin
      step();
      i_rst          = ($urandom_range(0, 199) == 0);
      bus.br_taken   = ($urandom_range(0, 29) == 0);
      bus.br_target  = $urandom;
      bus.line_valid = ($urandom_range(0, 9) < 7);
      bus.dq_ready   = ($urandom_range(0, 9) < 6);
      bus.line_in    = {$urandom, $urandom, $urandom, $urandom};
    end
    step();
    i_rst = 1'b0; bus.br_taken = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch front end sitting directly downstream of the instruction cache.
- Generates the line-aligned fetch PC and read enable for the cache, and captures the returned 128-bit lines into a small FIFO.
- Slices each line into four 32-bit instructions and hands them one per cycle, with their PCs, to decode over a valid/ready handshake.
- Handles branch redirect: flushes the queue, aborts the cache read, and restarts fetch at the target.

Parameters:
- DATA_WIDTH, 32, instruction and PC width.
- LINE_WIDTH, 128, cache line width; fixed at 4 instructions per line.
- DEPTH, 4, number of line entries in the queue; power of 2, at least 2.
- RESET_PC, 32'h0040_0000, first fetch address after reset; 16-byte aligned.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- i_rst, input, 1, synchronous active-high reset.
- pc_out, output, 32, line-aligned byte fetch address to the cache (pc_in).
- rd_en, output, 1, cache read request.
- abort, output, 1, cancels the cache access in the current cycle.
- line_in, input, 128, cache line data (dout).
- line_valid, input, 1, line_in is valid this cycle (dout_valid).
- br_taken, input, 1, redirect request from execute.
- br_target, input, 32, redirect byte address.
- dq_ready, input, 1, decode can accept an instruction this cycle.
- instr_out, output, 32, current instruction.
- instr_pc, output, 32, byte PC of instr_out.
- instr_valid, output, 1, instr_out and instr_pc are valid.
- q_full, output, 1, count == DEPTH.
- q_empty, output, 1, count == 0.

Behaviour:
- State:
  - fetch_pc (32 bits, bits [3:0] always 0).
  - Line FIFO of DEPTH entries, each holding {line[127:0], line_pc[31:0]}.
  - wr_ptr and rd_ptr, log2(DEPTH) bits each, wrap modulo DEPTH.
  - count, 0..DEPTH.
  - rd_word, 2 bits.
- Reset (i_rst high at a clock edge): fetch_pc=RESET_PC; count=0; wr_ptr=0; rd_ptr=0; rd_word=0; FIFO data is don't-care.
- Combinational outputs while i_rst is high: rd_en=0, abort=0, instr_valid=0.
- rd_en = !i_rst & !br_taken & (count < DEPTH). The check uses the registered count only; no same-cycle pop bypass.
- pc_out = fetch_pc at all times.
- abort = br_taken & !i_rst.
- Enqueue: when rd_en & line_valid (cache read is combinational, zero latency):
  - write {line_in, fetch_pc} at wr_ptr;
  - wr_ptr+1;
  - fetch_pc += 16, wrapping modulo 2^32.
- If rd_en & !line_valid: no enqueue, and fetch_pc holds.
- Output:
  - instr_valid = !q_empty & !br_taken & !i_rst.
  - instr_out = entry[rd_ptr].line[32*rd_word +: 32]; word 0 is bits [31:0].
  - instr_pc = entry[rd_ptr].line_pc + {rd_word, 2'b00}.
  - When q_empty: instr_out=0 and instr_pc=0.
- Dequeue: when instr_valid & dq_ready:
  - rd_word+1.
  - If rd_word==3: rd_word wraps to 0, rd_ptr+1, and the line is popped.
- Count update: +1 on enqueue, -1 on line pop. Enqueue and pop in the same cycle leave count unchanged.
- Redirect (br_taken high) has priority over enqueue and dequeue:
  - count=0; rd_ptr=wr_ptr=0; fetch_pc={br_target[31:4],4'b0}; rd_word=br_target[3:2].
  - The first line fetched after the redirect is therefore issued starting at the target word.
  - br_target[1:0] is ignored.
- br_taken while the queue is full or empty: same flush behaviour. No instruction is delivered in the redirect cycle, even if dq_ready=1.
- br_taken held for several cycles: the state stays flushed and fetch_pc tracks the latest target.
- Reset asserted mid-stream overrides redirect and all in-flight traffic.
- dq_ready low: instr_out, instr_pc and instr_valid hold stable. Fetch continues until q_full.
- Throughput: one instruction per cycle sustained. The queue refills one line per cycle.

Test Plan:
- Reset then release, with the cache returning line 0 = {32'h4,32'h3,32'h2,32'h1} and dq_ready=1 -> pc_out=32'h0040_0000 with rd_en=1 on the first cycle. On the following cycles instr_out is 1,2,3,4 with instr_pc 0x400000, 0x400004, 0x400008, 0x40000C, and pc_out steps to 0x400010.
- dq_ready=0 with line_valid=1 every cycle -> exactly DEPTH=4 lines enqueued; q_full=1 and rd_en=0 from the 5th cycle; pc_out holds at 0x400040; instr_out holds at word 0 of the first line.
- Queue full; raise dq_ready for 4 cycles -> the first line is popped on the 4th handshake; rd_en returns to 1 on the next cycle and one new line is enqueued at 0x400040; count stays at 4 after the refill.
- br_taken=1 with br_target=32'h0040_0128 while 3 lines are queued -> abort=1, rd_en=0 and instr_valid=0 that cycle. On the next cycle: q_empty=1 and pc_out=0x400120. After that line arrives: instr_pc=0x400128 (word 2), then 0x40012C, then 0x400130.
- br_taken and line_valid both high in the same cycle -> nothing is enqueued, and count=0 on the next cycle.
- i_rst pulsed for one cycle mid-stream with dq_ready=1 -> instr_valid=0 during the reset cycle, all queued data is discarded, and fetch restarts at 0x400000 with rd_word=0.
